// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the frame-granular AXI-Stream arbiter.
//
// Contents:
//   arb_state_t  - arbiter FSM state encoding (IDLE, PASS, DROP)
//   grant_width  - width of a source index for a given source count
//   rr_next      - round-robin successor of a source index
package axis_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } arb_state_t;

    localparam int NUM_SRC_MIN = 2;
    localparam int NUM_SRC_MAX = 8;

    function automatic int grant_width(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    function automatic int rr_next(input int idx, input int num_src);
        return (idx + 1 >= num_src) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry skid-buffer register slice for an AXI-Stream payload.
// Outputs are driven straight from registers; in_ready is registered
// (it is simply "skid entry empty"), so no combinational path runs from
// out_ready back to in_ready. Sustains one beat per cycle while
// out_ready stays high.
//
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   in_data/in_valid  - upstream payload and valid
//   in_ready          - upstream ready (slice not full)
//   out_data/out_valid- registered downstream payload and valid
//   out_ready         - downstream ready
module axis_reg_slice #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             in_fire;

    assign in_ready = !skid_valid;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // Output register is free this cycle: drain the skid entry
            // first (upstream is held off while it is occupied).
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_fire;
                if (in_fire) begin
                    out_data <= in_data;
                end
            end
        end else if (in_fire) begin
            // Output stalled: park the beat that was already in flight.
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter: merges NUM_SRC AXI-Stream byte
// sources onto one master. The grant is held from the first accepted
// beat of a frame through its accepted tlast beat; the merged stream is
// registered through axis_reg_slice.
//
// Optional build macro: ARB_TIMEOUT_EN adds a stall timeout. A granted
// source that stays idle for TIMEOUT_CYC cycles mid-frame is switched to
// DROP, where the rest of its frame is consumed and discarded, and its
// bit in err_timeout is set (sticky until reset).
//
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   s_axis_*       - NUM_SRC packed source streams, source i at
//                    tdata[i*DATA_WIDTH +: DATA_WIDTH]; tuser marks SOF
//   m_axis_*       - merged output stream
//   err_timeout    - per-source sticky timeout flags (ARB_TIMEOUT_EN only)
//   grant_id       - current or most recently granted source
//   busy           - a frame is locked (state != IDLE)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; pick the next valid source round-robin (registered)
// PASS  | forward beats of grant_id into the slice until tlast accepted
// DROP  | timed-out frame: consume grant_id beats, discard, until tlast
module axis_frame_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_SRC     = 2,
    parameter  int DATA_WIDTH  = 8,
    parameter  int TIMEOUT_CYC = 256,
    localparam int GRANT_W     = grant_width(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    input  logic [NUM_SRC-1:0]            s_axis_tuser,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic                          m_axis_tready,
`ifdef ARB_TIMEOUT_EN
    output logic [NUM_SRC-1:0]            err_timeout,
`endif
    output logic [GRANT_W-1:0]            grant_id,
    output logic                          busy
);

    if (NUM_SRC < NUM_SRC_MIN || NUM_SRC > NUM_SRC_MAX || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("axis_frame_arbiter: NUM_SRC must be 2..8 and TIMEOUT_CYC >= 1");
    end

    arb_state_t         state, state_nxt;
    logic [GRANT_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [GRANT_W-1:0] grant_nxt;
    logic [GRANT_W-1:0] winner;
    logic               win_found;

    logic                  sel_valid, sel_last, sel_user;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  src_ready;
    logic                  beat_fire;
    logic                  slice_in_valid, slice_in_ready;
`ifdef ARB_TIMEOUT_EN
    logic                  stall_tc;
`endif

    assign sel_valid = s_axis_tvalid[grant_id];
    assign sel_last  = s_axis_tlast[grant_id];
    assign sel_user  = s_axis_tuser[grant_id];
    assign sel_data  = s_axis_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];

    assign busy = (state != IDLE);

    always_comb begin
        src_ready = 1'b0;
        case (state)
            PASS:    src_ready = slice_in_ready;
            DROP:    src_ready = 1'b1;
            default: src_ready = 1'b0;
        endcase
    end

    assign beat_fire      = sel_valid && src_ready;
    assign slice_in_valid = (state == PASS) && sel_valid;

    always_comb begin
        s_axis_tready = '0;
        if (src_ready) begin
            s_axis_tready[grant_id] = 1'b1;
        end
    end

    // First valid source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!win_found && s_axis_tvalid[idx]) begin
                winner    = GRANT_W'(idx);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_id;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_nxt = winner;
                    state_nxt = PASS;
                end
            end
            PASS: begin
                if (beat_fire && sel_last) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = GRANT_W'(rr_next(int'(grant_id), NUM_SRC));
                end
`ifdef ARB_TIMEOUT_EN
                else if (stall_tc) begin
                    state_nxt = DROP;
                end
`endif
            end
            DROP: begin
                if (beat_fire && sel_last) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = GRANT_W'(rr_next(int'(grant_id), NUM_SRC));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_id <= grant_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    // Down-counter reloaded on every accepted beat; terminal count on a
    // stalled cycle means TIMEOUT_CYC consecutive idle cycles were seen.
    logic [STALL_W-1:0] stall_cnt;

    assign stall_tc = (state == PASS) && !sel_valid && (stall_cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt   <= STALL_W'(TIMEOUT_CYC - 1);
            err_timeout <= '0;
        end else begin
            if (state != PASS || beat_fire) begin
                stall_cnt <= STALL_W'(TIMEOUT_CYC - 1);
            end else if (!sel_valid && stall_cnt != '0) begin
                stall_cnt <= stall_cnt - 1'b1;
            end
            if (stall_tc) begin
                err_timeout[grant_id] <= 1'b1;
            end
        end
    end
`endif

    axis_reg_slice #(
        .WIDTH (DATA_WIDTH + 2)
    ) u_slice (
        .clk       (clk),
        .reset     (reset),
        .in_data   ({sel_user, sel_last, sel_data}),
        .in_valid  (slice_in_valid),
        .in_ready  (slice_in_ready),
        .out_data  ({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

endmodule
